// File: rtl/clock_monitor.sv
// Clock monitor: measures the period of a slow asynchronous clock in clk cycles,
// declares lock after a run of consistent periods and flags loss after a timeout.
module clock_monitor #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 20000000,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned TOL     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clear,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TimeoutW = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TolW     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] OneW     = CNT_W'(1);
  localparam logic [7:0]       LockW    = 8'(LOCK_N);

  typedef enum logic [1:0] {StIdle, StArmed, StLocked, StLost} state_e;

  state_e           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       match_cnt;
  logic             prev_valid;

  logic [CNT_W-1:0] diff;
  logic             in_tol;
  logic [7:0]       match_inc;
  logic             at_timeout;

  // Two-flop synchronizer plus history flop; clear deliberately leaves these alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_pulse = s2 & ~s3;

  // Period comparison: subtract smaller from larger so the difference never wraps.
  always_comb begin
    diff       = (cnt >= period) ? (cnt - period) : (period - cnt);
    in_tol     = (diff <= TolW);
    match_inc  = (match_cnt == 8'hFF) ? match_cnt : (match_cnt + 8'd1);
    at_timeout = (cnt == TimeoutW);
  end

  // Measurement FSM with registered outputs; clear overrides every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= '0;
      match_cnt    <= '0;
      prev_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else if (clear) begin
      state        <= StIdle;
      cnt          <= '0;
      match_cnt    <= '0;
      prev_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (rise_pulse) begin
            state      <= StArmed;
            cnt        <= OneW;
            match_cnt  <= '0;
            prev_valid <= 1'b0;
          end
        end
        StArmed, StLocked: begin
          // A rising edge wins over a coincident timeout.
          if (rise_pulse) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= OneW;
            prev_valid   <= 1'b1;
            if (prev_valid && in_tol) begin
              match_cnt <= match_inc;
              if ((state == StArmed) && (match_inc >= LockW)) begin
                state  <= StLocked;
                locked <= 1'b1;
              end
            end else if (prev_valid) begin
              match_cnt <= '0;
              if (state == StLocked) begin
                state  <= StArmed;
                locked <= 1'b0;
              end
            end
          end else if (at_timeout) begin
            state      <= StLost;
            lost       <= 1'b1;
            locked     <= 1'b0;
            cnt        <= '0;
            match_cnt  <= '0;
            prev_valid <= 1'b0;
          end else begin
            cnt <= cnt + OneW;
          end
        end
        StLost: begin
          lost <= 1'b1;
          if (rise_pulse) begin
            state      <= StArmed;
            lost       <= 1'b0;
            cnt        <= OneW;
            match_cnt  <= '0;
            prev_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: stimulus pushes expected {period, locked}
// for each edge that should produce period_valid; a monitor pops and compares.
module tb_clock_monitor;

  localparam int unsigned CntW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sig_in = 1'b0;
  logic            clear = 1'b0;
  logic            rise_pulse;
  logic [CntW-1:0] period;
  logic            period_valid;
  logic            locked;
  logic            lost;

  typedef struct {
    logic [31:0] per;
    logic        lk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_rp_cyc = 0;
  logic prev_rp = 1'b0;

  clock_monitor #(
    .CNT_W  (CntW),
    .TIMEOUT(1000),
    .LOCK_N (4),
    .TOL    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .clear       (clear),
    .rise_pulse  (rise_pulse),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every period_valid and checks strobe width.
  always @(negedge clk) begin
    if (rst) begin
      prev_rp = 1'b0;
    end else begin
      if (rise_pulse) begin
        last_rp_cyc = cyc;
        chk("rise_pulse_width", {31'd0, prev_rp}, 32'd0);
      end
      prev_rp = rise_pulse;
      if (period_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_period_valid", {31'd0, period_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("period", period, e.per);
          chk("locked_at_period_valid", {31'd0, locked}, {31'd0, e.lk});
        end
      end
    end
  end

  // One sig_in cycle: high for hi clk cycles then low for lo; optionally expects
  // a period_valid carrying per (the previous cycle's length) with locked=lk.
  task automatic rise(input int hi, input int lo, input bit pv, input int per, input bit lk);
    exp_t e;
    if (pv) begin
      e.per = per;
      e.lk  = lk;
      q.push_back(e);
    end
    sig_in = 1'b1;
    repeat (hi) @(negedge clk);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_period", period, 0);
    chk("reset_period_valid", {31'd0, period_valid}, 0);
    chk("reset_locked", {31'd0, locked}, 0);
    chk("reset_lost", {31'd0, lost}, 0);
    chk("reset_rise_pulse", {31'd0, rise_pulse}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Steady 100-cycle period: first rise only arms, lock on the sixth rise
    rise(50, 50, 0, 0, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 50, 1, 100, 1);
    // Jitter within tolerance keeps lock; 110 breaks it
    rise(50, 51, 1, 100, 1);
    rise(50, 49, 1, 101, 1);
    rise(50, 50, 1, 99, 1);
    rise(50, 60, 1, 100, 1);
    rise(50, 0, 1, 110, 0);

    // sig_in stops: loss declared the cycle after cnt reaches TIMEOUT
    n = 0;
    while (!lost && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("lost_asserted", {31'd0, lost}, 1);
    chk("lost_latency", cyc - last_rp_cyc, 1001);
    chk("lost_period_kept", period, 110);
    chk("lost_locked", {31'd0, locked}, 0);
    repeat (10) @(negedge clk);
    chk("lost_held", {31'd0, lost}, 1);

    // Recovery: first rise clears lost without period_valid, history discarded
    rise(50, 50, 0, 0, 0);
    chk("lost_cleared", {31'd0, lost}, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 50, 1, 100, 0);
    rise(50, 0, 1, 100, 1);
    chk("locked_before_rst", {31'd0, locked}, 1);

    // Asynchronous reset mid-measurement
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_period", period, 0);
    chk("arst_period_valid", {31'd0, period_valid}, 0);
    chk("arst_locked", {31'd0, locked}, 0);
    chk("arst_lost", {31'd0, lost}, 0);
    chk("arst_rise_pulse", {31'd0, rise_pulse}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rise(50, 50, 0, 0, 0);
    rise(50, 50, 1, 100, 0);

    // Clear coincident with rise_pulse: clear wins, no period_valid
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rise_pulse_latency", {31'd0, rise_pulse}, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_period_valid", {31'd0, period_valid}, 0);
    chk("clear_period", period, 0);
    chk("clear_locked", {31'd0, locked}, 0);
    repeat (47) @(negedge clk);
    sig_in = 1'b0;
    repeat (50) @(negedge clk);

    // Toggle divider n=5: period 10, lock after LOCK_N+2 rises
    rise(5, 5, 0, 0, 0);
    rise(5, 5, 1, 10, 0);
    rise(5, 5, 1, 10, 0);
    rise(5, 5, 1, 10, 0);
    rise(5, 5, 1, 10, 0);
    rise(5, 5, 1, 10, 1);
    rise(5, 5, 1, 10, 1);
    rise(5, 5, 1, 10, 1);
    repeat (20) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
